// File: rtl/tid_ctrl_pkg.sv
// Shared types for the TID allocator: default TID width, TID type and FSM states.
package tid_ctrl_pkg;

  localparam int TID_W_DEF = 8;

  typedef logic [TID_W_DEF-1:0] tid_t;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

endpackage

// File: rtl/tid_free_fifo.sv
// Free-list FIFO of unused TIDs: distributed RAM with a registered head that
// always mirrors the slot the read pointer addresses.
module tid_free_fifo #(
  parameter int TID_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [TID_W-1:0] push_data,
  input  logic             pop,
  output logic [TID_W-1:0] head,
  output logic             empty
);

  localparam int DEPTH = 2**TID_W;
  localparam logic [TID_W:0] PTR_ONE = (TID_W+1)'(1);

  logic [TID_W-1:0] mem [DEPTH];
  logic [TID_W:0]   wr_ptr;
  logic [TID_W:0]   rd_ptr;
  logic [TID_W:0]   rd_nxt;

  assign rd_nxt = pop ? rd_ptr + PTR_ONE : rd_ptr;
  assign empty  = (wr_ptr == rd_ptr);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[TID_W-1:0]] <= push_data;
  end

  // A push landing on the slot that becomes the head is forwarded so the head
  // register never holds the stale RAM word for that slot.
  always_ff @(posedge clk) begin
    if (push && (wr_ptr[TID_W-1:0] == rd_nxt[TID_W-1:0])) head <= push_data;
    else                                                   head <= mem[rd_nxt[TID_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      rd_ptr <= rd_nxt;
    end
  end

endmodule

// File: rtl/tid_alloc_ctrl.sv
// TID allocator: fills the free list after reset, grants TIDs with zero latency
// and reclaims retired ones. Define TID_DBL_FREE_CHK_EN for double-retire detection.
module tid_alloc_ctrl
  import tid_ctrl_pkg::*;
#(
  parameter int TID_W   = TID_W_DEF,
  parameter int MAX_OUT = 256
) (
  input  logic             lnk_clk,
  input  logic             lnk_reset,
  output logic             tid_rdy,
  output logic [TID_W:0]   tid_out_cnt,
  input  logic             alloc_req,
  output logic             alloc_gnt,
  output logic             alloc_avail,
  output logic [TID_W-1:0] alloc_tid,
  input  logic             ret_vld,
  input  logic [TID_W-1:0] ret_tid,
  output logic             ret_err
);

  localparam logic [TID_W:0]   MAX_CNT = (TID_W+1)'(MAX_OUT);
  localparam logic [TID_W:0]   CNT_ONE = (TID_W+1)'(1);
  localparam logic [TID_W-1:0] TID_ONE = TID_W'(1);

  state_t           state;
  logic [TID_W-1:0] init_cnt;
  logic             fifo_empty;
  logic             push;
  logic [TID_W-1:0] push_data;
  logic             ret_ok;

  assign alloc_avail = tid_rdy & (tid_out_cnt < MAX_CNT) & ~fifo_empty;
  assign alloc_gnt   = alloc_req & alloc_avail;

`ifdef TID_DBL_FREE_CHK_EN
  localparam int DEPTH = 2**TID_W;

  logic [DEPTH-1:0] out_map;

  assign ret_ok = tid_rdy & ret_vld & (tid_out_cnt != '0) & out_map[ret_tid];

  // Grant and legal retire never name the same TID: a granted TID is free,
  // so its bit is clear, while a legal retire needs its bit set.
  always_ff @(posedge lnk_clk) begin
    if (state == ST_INIT) begin
      out_map[init_cnt] <= 1'b0;
    end else begin
      if (alloc_gnt) out_map[alloc_tid] <= 1'b1;
      if (ret_ok)    out_map[ret_tid]   <= 1'b0;
    end
  end
`else
  assign ret_ok = tid_rdy & ret_vld & (tid_out_cnt != '0);
`endif

  assign push      = (state == ST_INIT) | ret_ok;
  assign push_data = (state == ST_INIT) ? init_cnt : ret_tid;

  tid_free_fifo #(
    .TID_W (TID_W)
  ) u_free_fifo (
    .clk       (lnk_clk),
    .rst       (lnk_reset),
    .push      (push),
    .push_data (push_data),
    .pop       (alloc_gnt),
    .head      (alloc_tid),
    .empty     (fifo_empty)
  );

  always_ff @(posedge lnk_clk) begin
    if (lnk_reset) begin
      state       <= ST_INIT;
      tid_rdy     <= 1'b0;
      init_cnt    <= '0;
      tid_out_cnt <= '0;
      ret_err     <= 1'b0;
    end else begin
      ret_err <= tid_rdy & ret_vld & ~ret_ok;
      unique case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + TID_ONE;
          if (&init_cnt) begin
            state   <= ST_RUN;
            tid_rdy <= 1'b1;
          end
        end
        ST_RUN: begin
          case ({alloc_gnt, ret_ok})
            2'b10:   tid_out_cnt <= tid_out_cnt + CNT_ONE;
            2'b01:   tid_out_cnt <= tid_out_cnt - CNT_ONE;
            default: tid_out_cnt <= tid_out_cnt;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tid_alloc_ctrl.sv
// Self-checking bench for tid_alloc_ctrl: directed scenarios plus randomized
// traffic against a queue-based free-list model.
module tb_tid_alloc_ctrl;
  import tid_ctrl_pkg::*;

  localparam int DEPTH = 256;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, a_rv, a_rdy, a_gnt, a_avail, a_err;
  tid_t       a_rt, a_tid;
  logic [8:0] a_cnt;
  logic       b_req, b_rv, b_rdy, b_gnt, b_avail, b_err;
  tid_t       b_rt, b_tid;
  logic [8:0] b_cnt;

  always #5 clk = ~clk;

  tid_alloc_ctrl #(.TID_W(8), .MAX_OUT(256)) dut_a (
    .lnk_clk(clk), .lnk_reset(rst), .tid_rdy(a_rdy), .tid_out_cnt(a_cnt),
    .alloc_req(a_req), .alloc_gnt(a_gnt), .alloc_avail(a_avail), .alloc_tid(a_tid),
    .ret_vld(a_rv), .ret_tid(a_rt), .ret_err(a_err));

  tid_alloc_ctrl #(.TID_W(8), .MAX_OUT(4)) dut_b (
    .lnk_clk(clk), .lnk_reset(rst), .tid_rdy(b_rdy), .tid_out_cnt(b_cnt),
    .alloc_req(b_req), .alloc_gnt(b_gnt), .alloc_avail(b_avail), .alloc_tid(b_tid),
    .ret_vld(b_rv), .ret_tid(b_rt), .ret_err(b_err));

  int n_vec = 0;
  int n_bad = 0;

  // Reference model of dut_a: free list as a queue, outstanding TIDs as a list.
  int q[$];
  int outq[$];
  bit mmap[DEPTH];
  int mcnt;
  bit mrdy, merr;
  bit e_avail, e_gnt;
  int e_tid;

  task automatic model_fill();
    q.delete();
    outq.delete();
    for (int i = 0; i < DEPTH; i++) begin
      q.push_back(i);
      mmap[i] = 1'b0;
    end
    mcnt = 0;
    mrdy = 1'b1;
    merr = 1'b0;
  endtask

  task automatic idle_inputs();
    a_req = 0; a_rv = 0; a_rt = '0;
    b_req = 0; b_rv = 0; b_rt = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    repeat (DEPTH) @(negedge clk);
    model_fill();
  endtask

  // Drive one cycle's inputs into dut_a and form the model's predictions.
  task automatic apply(input bit req, input bit rv, input int rt);
    a_req = req;
    a_rv  = rv;
    a_rt  = tid_t'(rt);
    #1;
    e_avail = mrdy && (mcnt < DEPTH) && (q.size() > 0);
    e_gnt   = req && e_avail;
    e_tid   = (q.size() > 0) ? q[0] : 0;
  endtask

  // Advance the model through the clock edge for the applied inputs.
  task automatic tick();
    bit legal;
    int t;
    legal = mrdy && a_rv && (mcnt > 0);
`ifdef TID_DBL_FREE_CHK_EN
    legal = legal && mmap[a_rt];
`endif
    merr = mrdy && a_rv && !legal;
    if (e_gnt) begin
      t = q.pop_front();
      mmap[t] = 1'b1;
      outq.push_back(t);
      mcnt++;
    end
    if (legal) begin
      q.push_back(int'(a_rt));
      mmap[a_rt] = 1'b0;
      for (int k = 0; k < outq.size(); k++) begin
        if (outq[k] == int'(a_rt)) begin
          outq.delete(k);
          break;
        end
      end
      mcnt--;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    #1;
    n_vec++; if (a_rdy !== 1'b0)  begin n_bad++; $display("FAIL rst_rdy: got %b want 0", a_rdy); end
    n_vec++; if (a_cnt !== 9'd0)  begin n_bad++; $display("FAIL rst_cnt: got %0d want 0", a_cnt); end
    n_vec++; if (a_avail !== 1'b0) begin n_bad++; $display("FAIL rst_avail: got %b want 0", a_avail); end
    n_vec++; if (a_gnt !== 1'b0)  begin n_bad++; $display("FAIL rst_gnt: got %b want 0", a_gnt); end
    n_vec++; if (a_err !== 1'b0)  begin n_bad++; $display("FAIL rst_err: got %b want 0", a_err); end
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      n_vec++;
      if (a_rdy !== 1'b0) begin n_bad++; $display("FAIL init_rdy[%0d]: got %b want 0", i, a_rdy); end
      @(negedge clk);
      #1;
    end
    n_vec++; if (a_rdy !== 1'b1)  begin n_bad++; $display("FAIL init_done_rdy: got %b want 1", a_rdy); end
    n_vec++; if (b_rdy !== 1'b1)  begin n_bad++; $display("FAIL init_done_rdy_b: got %b want 1", b_rdy); end
    n_vec++; if (a_avail !== 1'b1) begin n_bad++; $display("FAIL init_done_avail: got %b want 1", a_avail); end
    n_vec++; if (a_tid !== 8'd0)  begin n_bad++; $display("FAIL init_done_tid: got %0d want 0", a_tid); end
    @(negedge clk);
    model_fill();
  endtask

  task automatic test_basic_alloc();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, 0);
      n_vec++; if (a_gnt !== 1'b1) begin n_bad++; $display("FAIL basic_gnt[%0d]: got %b want 1", i, a_gnt); end
      n_vec++; if (a_tid !== tid_t'(i)) begin n_bad++; $display("FAIL basic_tid[%0d]: got %0d want %0d", i, a_tid, i); end
      tick();
    end
    apply(0, 0, 0);
    n_vec++; if (a_cnt !== 9'd3) begin n_bad++; $display("FAIL basic_cnt: got %0d want 3", a_cnt); end
    tick();
  endtask

  task automatic test_max_out();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      b_req = 1'b1;
      #1;
      n_vec++; if (b_gnt !== 1'b1) begin n_bad++; $display("FAIL max_gnt[%0d]: got %b want 1", i, b_gnt); end
      n_vec++; if (b_tid !== tid_t'(i)) begin n_bad++; $display("FAIL max_tid[%0d]: got %0d want %0d", i, b_tid, i); end
      @(negedge clk);
    end
    #1;
    n_vec++; if (b_avail !== 1'b0) begin n_bad++; $display("FAIL max_avail: got %b want 0", b_avail); end
    n_vec++; if (b_gnt !== 1'b0)   begin n_bad++; $display("FAIL max_gnt_block: got %b want 0", b_gnt); end
    n_vec++; if (b_cnt !== 9'd4)   begin n_bad++; $display("FAIL max_cnt: got %0d want 4", b_cnt); end
    b_rv = 1'b1;
    b_rt = 8'd2;
    @(negedge clk);
    b_rv = 1'b0;
    #1;
    n_vec++; if (b_avail !== 1'b1) begin n_bad++; $display("FAIL max_reavail: got %b want 1", b_avail); end
    n_vec++; if (b_gnt !== 1'b1)   begin n_bad++; $display("FAIL max_regnt: got %b want 1", b_gnt); end
    n_vec++; if (b_tid !== 8'd4)   begin n_bad++; $display("FAIL max_retid: got %0d want 4", b_tid); end
    @(negedge clk);
    b_req = 1'b0;
    #1;
    n_vec++; if (b_cnt !== 9'd4)   begin n_bad++; $display("FAIL max_cnt_end: got %0d want 4", b_cnt); end
    @(negedge clk);
  endtask

  task automatic test_full_list();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      apply(1, 0, 0);
      n_vec++; if (a_gnt !== 1'b1 || a_tid !== tid_t'(i)) begin
        n_bad++; $display("FAIL full_grant[%0d]: got gnt=%b tid=%0d want gnt=1 tid=%0d", i, a_gnt, a_tid, i);
      end
      tick();
    end
    apply(0, 0, 0);
    n_vec++; if (a_avail !== 1'b0) begin n_bad++; $display("FAIL full_avail: got %b want 0", a_avail); end
    n_vec++; if (a_cnt !== 9'd256) begin n_bad++; $display("FAIL full_cnt: got %0d want 256", a_cnt); end
    tick();
    apply(0, 1, 7);
    tick();
    apply(1, 1, 9);
    n_vec++; if (a_gnt !== 1'b1 || a_tid !== 8'd7) begin
      n_bad++; $display("FAIL full_regrant: got gnt=%b tid=%0d want gnt=1 tid=7", a_gnt, a_tid);
    end
    tick();
    apply(0, 0, 0);
    n_vec++; if (a_cnt !== 9'd255) begin n_bad++; $display("FAIL full_cnt_swap: got %0d want 255", a_cnt); end
    n_vec++; if (a_tid !== 8'd9)   begin n_bad++; $display("FAIL full_head9: got %0d want 9", a_tid); end
    tick();
    apply(1, 0, 0);
    tick();
    apply(1, 1, 3);
    n_vec++; if (a_avail !== 1'b0 || a_gnt !== 1'b0) begin
      n_bad++; $display("FAIL no_bypass: got avail=%b gnt=%b want 0 0", a_avail, a_gnt);
    end
    tick();
    apply(0, 0, 0);
    n_vec++; if (a_avail !== 1'b1 || a_tid !== 8'd3) begin
      n_bad++; $display("FAIL bypass_next: got avail=%b tid=%0d want 1 3", a_avail, a_tid);
    end
    n_vec++; if (a_cnt !== 9'd255) begin n_bad++; $display("FAIL bypass_cnt: got %0d want 255", a_cnt); end
    tick();
  endtask

  task automatic test_retire_empty();
    do_reset();
    apply(0, 1, 5);
    n_vec++; if (a_err !== 1'b0) begin n_bad++; $display("FAIL rete_pre: got %b want 0", a_err); end
    tick();
    apply(0, 0, 0);
    n_vec++; if (a_err !== 1'b1) begin n_bad++; $display("FAIL rete_err: got %b want 1", a_err); end
    n_vec++; if (a_cnt !== 9'd0) begin n_bad++; $display("FAIL rete_cnt: got %0d want 0", a_cnt); end
    tick();
    apply(1, 0, 0);
    n_vec++; if (a_err !== 1'b0) begin n_bad++; $display("FAIL rete_pulse: got %b want 0", a_err); end
    n_vec++; if (a_gnt !== 1'b1 || a_tid !== 8'd0) begin
      n_bad++; $display("FAIL rete_grant: got gnt=%b tid=%0d want 1 0", a_gnt, a_tid);
    end
    tick();
  endtask

  task automatic test_double_retire();
    do_reset();
    apply(1, 0, 0);
    n_vec++; if (a_tid !== 8'd0) begin n_bad++; $display("FAIL dbl_tid: got %0d want 0", a_tid); end
    tick();
    apply(0, 1, 0);
    tick();
    apply(0, 1, 0);
    n_vec++; if (a_err !== 1'b0) begin n_bad++; $display("FAIL dbl_first: got %b want 0", a_err); end
    n_vec++; if (a_cnt !== 9'd0) begin n_bad++; $display("FAIL dbl_cnt1: got %0d want 0", a_cnt); end
    tick();
    apply(0, 0, 0);
    n_vec++; if (a_err !== 1'b1) begin n_bad++; $display("FAIL dbl_second: got %b want 1", a_err); end
    n_vec++; if (a_cnt !== 9'd0) begin n_bad++; $display("FAIL dbl_cnt2: got %0d want 0", a_cnt); end
    tick();
    apply(1, 0, 0);
    tick();
    apply(0, 1, 200);
    tick();
    apply(0, 0, 0);
    n_vec++; if (a_err !== merr) begin n_bad++; $display("FAIL never_issued_err: got %b want %b", a_err, merr); end
    n_vec++; if (a_cnt !== 9'(mcnt)) begin n_bad++; $display("FAIL never_issued_cnt: got %0d want %0d", a_cnt, mcnt); end
    tick();
  endtask

  task automatic test_reset_in_run();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      apply(1, 0, 0);
      tick();
    end
    apply(0, 0, 0);
    n_vec++; if (a_cnt !== 9'd10) begin n_bad++; $display("FAIL rrun_cnt10: got %0d want 10", a_cnt); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (a_rdy !== 1'b0) begin n_bad++; $display("FAIL rrun_rdy: got %b want 0", a_rdy); end
    n_vec++; if (a_cnt !== 9'd0) begin n_bad++; $display("FAIL rrun_cnt: got %0d want 0", a_cnt); end
    repeat (DEPTH - 1) @(negedge clk);
    #1;
    n_vec++; if (a_rdy !== 1'b0) begin n_bad++; $display("FAIL rrun_early: got %b want 0", a_rdy); end
    @(negedge clk);
    model_fill();
    apply(1, 0, 0);
    n_vec++; if (a_rdy !== 1'b1) begin n_bad++; $display("FAIL rrun_ready: got %b want 1", a_rdy); end
    n_vec++; if (a_gnt !== 1'b1 || a_tid !== 8'd0) begin
      n_bad++; $display("FAIL rrun_grant: got gnt=%b tid=%0d want 1 0", a_gnt, a_tid);
    end
    tick();
  endtask

  task automatic test_random();
    int req_pct, rv_pct, rt;
    bit req, rv;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      case ((c / 500) % 3)
        0:       begin req_pct = 90; rv_pct = 30; end
        1:       begin req_pct = 50; rv_pct = 50; end
        default: begin req_pct = 20; rv_pct = 80; end
      endcase
      req = ($urandom_range(99) < req_pct);
      rv  = 1'b0;
      rt  = 0;
      if (outq.size() > 0) begin
        if ($urandom_range(99) < rv_pct) begin
          rv = 1'b1;
          rt = outq[$urandom_range(outq.size() - 1)];
        end
      end else if ($urandom_range(9) == 0) begin
        rv = 1'b1;
        rt = $urandom_range(DEPTH - 1);
      end
      apply(req, rv, rt);
      n_vec++; if (a_avail !== e_avail) begin n_bad++; $display("FAIL rnd_avail@%0d: got %b want %b", c, a_avail, e_avail); end
      n_vec++; if (a_gnt !== e_gnt) begin n_bad++; $display("FAIL rnd_gnt@%0d: got %b want %b", c, a_gnt, e_gnt); end
      n_vec++; if (a_cnt !== 9'(mcnt)) begin n_bad++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", c, a_cnt, mcnt); end
      n_vec++; if (a_err !== merr) begin n_bad++; $display("FAIL rnd_err@%0d: got %b want %b", c, a_err, merr); end
      if (e_avail) begin
        n_vec++; if (a_tid !== tid_t'(e_tid)) begin n_bad++; $display("FAIL rnd_tid@%0d: got %0d want %0d", c, a_tid, e_tid); end
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_basic_alloc();
    test_max_out();
    test_full_list();
    test_retire_empty();
    test_double_retire();
    test_reset_in_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
